inst_fetch_mem: RTL

INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

---
 rtl/inst_fetch_mem_if.sv | 40 ++++
 rtl/inst_fetch_mem.sv | 85 ++++++++
 2 files changed

// File: rtl/inst_fetch_mem_if.sv
`default_nettype none
// ============================================================================
// inst_fetch_mem_if : fetch request / response bus of the instruction memory
// Revision 1.0
// ============================================================================
interface inst_fetch_mem_if #(
  parameter int ADDR_W = 8,
  parameter int OPC_W  = 5,
  parameter int REG_W  = 4,
  parameter int IMM_W  = 8
);
  localparam int INST_W = OPC_W + 3*REG_W + IMM_W;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [INST_W-1:0] resp_inst;
  logic [OPC_W-1:0]  resp_opcode;
  logic [REG_W-1:0]  resp_dest;
  logic [REG_W-1:0]  resp_src1;
  logic [REG_W-1:0]  resp_src2;
  logic [IMM_W-1:0]  resp_imm;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_inst, resp_opcode, resp_dest,
           resp_src1, resp_src2, resp_imm, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_inst, resp_opcode, resp_dest,
           resp_src1, resp_src2, resp_imm, resp_err
  );
endinterface

`default_nettype wire

// File: rtl/inst_fetch_mem.sv
`default_nettype none
// ============================================================================
// inst_fetch_mem : instruction memory with program-load port, synchronous
//                  fetch into a 2-entry response FIFO and field decode
// Revision 1.0
// ============================================================================
module inst_fetch_mem #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int OPC_W  = 5,
  parameter int REG_W  = 4,
  parameter int IMM_W  = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              ld_en,
  input  logic [ADDR_W-1:0]                 ld_addr,
  input  logic [OPC_W+3*REG_W+IMM_W-1:0]    ld_data,
  inst_fetch_mem_if.slave                   bus
);
  localparam int              INST_W  = OPC_W + 3*REG_W + IMM_W;
  localparam int              c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

  logic [INST_W-1:0] r_mem      [DEPTH];
  logic [INST_W-1:0] r_buf_inst [2];
  logic              r_buf_err  [2];
  logic [1:0]        r_occ;

  logic              w_req_in_range;
  logic              w_ld_in_range;
  logic              w_resp_valid;
  logic              w_pop;
  logic              w_accept;
  logic [1:0]        w_occ_after_pop;
  logic [INST_W-1:0] w_rd_data;

  assign w_req_in_range  = ({1'b0, bus.req_addr} < c_depth);
  assign w_ld_in_range   = ({1'b0, ld_addr} < c_depth);
  assign w_resp_valid    = !reset && (r_occ != 2'd0);
  assign w_pop           = w_resp_valid && bus.resp_ready;
  assign w_occ_after_pop = r_occ - {1'b0, w_pop};
  assign bus.req_ready   = !reset && !flush && (w_occ_after_pop < 2'd2);
  assign w_accept        = bus.req_valid && bus.req_ready;
  assign w_rd_data       = w_req_in_range ? r_mem[bus.req_addr[c_idx_w-1:0]] : '0;

  // Non-blocking write gives read-before-write on a same-cycle load/fetch.
  always_ff @(posedge clk) begin
    if (!reset && ld_en && w_ld_in_range) begin
      r_mem[ld_addr[c_idx_w-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_occ <= 2'd0;
    end else begin
      r_occ <= w_occ_after_pop + {1'b0, w_accept};
    end
  end

  // The read lands in the slot just behind the surviving entries.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_buf_inst[0] <= r_buf_inst[1];
      r_buf_err[0]  <= r_buf_err[1];
    end
    if (w_accept) begin
      r_buf_inst[w_occ_after_pop[0]] <= w_rd_data;
      r_buf_err[w_occ_after_pop[0]]  <= !w_req_in_range;
    end
  end

  assign bus.resp_valid  = w_resp_valid;
  assign bus.resp_inst   = w_resp_valid ? r_buf_inst[0] : '0;
  assign bus.resp_err    = w_resp_valid && r_buf_err[0];
  assign bus.resp_opcode = bus.resp_inst[INST_W-1 -: OPC_W];
  assign bus.resp_dest   = bus.resp_inst[INST_W-OPC_W-1 -: REG_W];
  assign bus.resp_src1   = bus.resp_inst[INST_W-OPC_W-REG_W-1 -: REG_W];
  assign bus.resp_src2   = bus.resp_inst[IMM_W+REG_W-1 -: REG_W];
  assign bus.resp_imm    = bus.resp_inst[IMM_W-1:0];
endmodule

`default_nettype wire
